// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// control-flow opcodes and the field widths used to pull a jump target
// out of an instruction word.
package fetch_pkg;

   localparam int INSTR_W_DEF = 9;   // default instruction word width
   localparam int OP_W        = 3;   // opcode field, top bits of the word
   localparam int TGT_W       = 6;   // target field, low bits of the word
   localparam int JV_W        = 8;   // jump_value width towards the PC block

   localparam logic [OP_W-1:0] OP_HALT = 3'b000;
   localparam logic [OP_W-1:0] OP_BZ   = 3'b110;
   localparam logic [OP_W-1:0] OP_JMP  = 3'b111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DISCARD = 2'd1,
      RUN     = 2'd2,
      HALTED  = 2'd3
   } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-flow decode of the current instruction word.
// Flags halt (the all-zero word), taken jumps (JMP always, BZ on zero_flag)
// and produces the zero-extended absolute target.
module ctrl_decode import fetch_pkg::*; #(
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               zero_flag,
   output logic               is_halt,
   output logic               is_jump,
   output logic [JV_W-1:0]    target
);

   logic [OP_W-1:0]  op;
   logic [TGT_W-1:0] tgt;

   assign op  = imem_data[TGT_W +: OP_W];
   assign tgt = imem_data[TGT_W-1:0];

   // opcode classification; everything not matched here retires as a plain instruction
   always_comb begin
      is_halt = (op == OP_HALT) && (tgt == '0);
      is_jump = (op == OP_JMP) || ((op == OP_BZ) && zero_flag);
      target  = {{(JV_W-TGT_W){1'b0}}, tgt};
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: watches the synchronous instruction memory,
// redirects or holds the PC on control-flow words, drops the one stale
// word that follows a start or a taken jump, and counts retirements.
module fetch_sequencer import fetch_pkg::*; #(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [15:0]        pc,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               zero_flag,
   output logic               jump,
   output logic [JV_W-1:0]    jump_value,
   output logic               halt,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   output logic               done,
   output logic [CNT_W-1:0]   retired
);

   state_t          state, state_nxt;
   logic            dec_halt, dec_jump;
   logic [JV_W-1:0] dec_target;
   logic            fresh;   // set by start, cleared once the first RUN cycle is reached

   ctrl_decode #(.INSTR_W(INSTR_W)) u_decode (
      .imem_data (imem_data),
      .zero_flag (zero_flag),
      .is_halt   (dec_halt),
      .is_jump   (dec_jump),
      .target    (dec_target)
   );

   // Retire counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state logic; start overrides every other transition
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = DISCARD;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            DISCARD: state_nxt = RUN;
            RUN: begin
               if (dec_halt)      state_nxt = HALTED;
               else if (dec_jump) state_nxt = DISCARD;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // outputs to the PC block and datapath; halt and jump are exclusive by construction
   always_comb begin
      jump        = 1'b0;
      jump_value  = dec_target;
      halt        = 1'b0;
      instr_valid = 1'b0;
      case (state)
         IDLE, HALTED: halt = 1'b1;
         RUN: begin
            instr_valid = 1'b1;
            if (dec_halt)      halt = 1'b1;
            else if (dec_jump) jump = 1'b1;
         end
         default: ;
      endcase
   end

   assign instr_out = imem_data;

   // retire count, done pulse on the RUN->HALTED edge, and post-start marker
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired <= '0;
         done    <= 1'b0;
         fresh   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            retired <= '0;
            fresh   <= 1'b1;
         end else begin
            if (instr_valid)                 retired <= sat_inc(retired);
            if (state == RUN && dec_halt)    done    <= 1'b1;
            if (state == RUN)                fresh   <= 1'b0;
         end
      end
   end

   // The word retiring in the first RUN cycle after start is fetched during
   // the DISCARD cycle, so the PC must already be back at address 0 there.
   a_first_fetch_at_zero: assert property (
      @(posedge clk) disable iff (reset)
      (state == DISCARD && fresh) |-> (pc == 16'd0)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small PC + synchronous memory model.
module tb_fetch_sequencer;

   localparam int CNT_W = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [15:0]       pc = 16'd0;
   logic [8:0]        imem_data = 9'd0;
   logic              zero_flag = 1'b0;
   logic              jump;
   logic [7:0]        jump_value;
   logic              halt;
   logic [8:0]        instr_out;
   logic              instr_valid;
   logic              done;
   logic [CNT_W-1:0]  retired;

   logic [8:0] mem [64];

   int checks = 0;
   int failures = 0;

   fetch_sequencer #(.INSTR_W(9), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pc          (pc),
      .imem_data   (imem_data),
      .zero_flag   (zero_flag),
      .jump        (jump),
      .jump_value  (jump_value),
      .halt        (halt),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .done        (done),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   // PC block and 1-cycle-latency instruction memory
   always @(posedge clk) begin
      imem_data <= mem[pc[5:0]];
      if (start)      pc <= 16'd0;
      else if (jump)  pc <= {8'd0, jump_value};
      else if (!halt) pc <= pc + 16'd1;
   end

   typedef struct {
      logic             start;
      logic             zf;
      logic             jmp;
      logic [7:0]       jv;
      logic             hlt;
      logic             vld;
      logic [8:0]       instr;
      logic [CNT_W-1:0] ret;
      logic             dn;
      logic [15:0]      pcv;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 9'h041;
      // jump program: 0,1 plain, 2 = JMP 10, 3 stale, 10 plain, 11 HALT
      mem[0] = 9'h041; mem[1] = 9'h042; mem[2] = 9'h1CA; mem[3] = 9'h043;
      mem[10] = 9'h044; mem[11] = 9'h000; mem[12] = 9'h045;

      //            start zf jmp jv     hlt vld instr    ret   dn pc
      vecs[0] = '{1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 9'h041, 4'd0, 1'b0, 16'd0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 9'h041, 4'd0, 1'b0, 16'd0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 9'h041, 4'd0, 1'b0, 16'd1};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 9'h042, 4'd1, 1'b0, 16'd2};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 8'd10, 1'b0, 1'b1, 9'h1CA, 4'd2, 1'b0, 16'd3};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 9'h043, 4'd3, 1'b0, 16'd10};
      vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 9'h044, 4'd3, 1'b0, 16'd11};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 9'h000, 4'd4, 1'b0, 16'd12};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 9'h045, 4'd5, 1'b1, 16'd12};
      vecs[9] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 9'h045, 4'd5, 1'b0, 16'd12};

      // reset for 3 cycles, then idle without start
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("idle%0d.halt", i), halt, 1);
         check($sformatf("idle%0d.jump", i), jump, 0);
         check($sformatf("idle%0d.valid", i), instr_valid, 0);
         check($sformatf("idle%0d.retired", i), retired, 0);
         tick();
      end

      // table-driven run through the jump program
      for (int i = 0; i < 10; i++) begin
         start = vecs[i].start;
         zero_flag = vecs[i].zf;
         #1;
         check($sformatf("v%0d.jump", i), jump, vecs[i].jmp);
         if (vecs[i].jmp) check($sformatf("v%0d.jump_value", i), jump_value, vecs[i].jv);
         check($sformatf("v%0d.halt", i), halt, vecs[i].hlt);
         check($sformatf("v%0d.valid", i), instr_valid, vecs[i].vld);
         check($sformatf("v%0d.instr", i), instr_out, vecs[i].instr);
         check($sformatf("v%0d.retired", i), retired, vecs[i].ret);
         check($sformatf("v%0d.done", i), done, vecs[i].dn);
         check($sformatf("v%0d.pc", i), pc, vecs[i].pcv);
         @(posedge clk);
         #0;
      end
      #1 start = 1'b0;

      // linear run ending in HALT
      mem[0] = 9'h041; mem[1] = 9'h042; mem[2] = 9'h043; mem[3] = 9'h044; mem[4] = 9'h000;
      do_start();
      check("lin.discard_valid", instr_valid, 0);
      tick();
      check("lin.first_valid", instr_valid, 1);
      check("lin.first_instr", instr_out, 9'h041);
      repeat (4) tick();
      check("lin.halt_instr", instr_out, 9'h000);
      check("lin.halt_valid", instr_valid, 1);
      check("lin.halt_same_cycle", halt, 1);
      check("lin.halt_no_jump", jump, 0);
      tick();
      check("lin.done", done, 1);
      check("lin.retired", retired, 5);
      check("lin.halted_valid", instr_valid, 0);
      tick();
      check("lin.done_once", done, 0);
      check("lin.still_halted", halt, 1);

      // conditional branch at addr 1, untaken then taken
      mem[1] = 9'h185; mem[2] = 9'h042; mem[5] = 9'h043;
      zero_flag = 1'b0;
      do_start();
      tick(); tick();
      check("bz0.jump", jump, 0);
      check("bz0.valid", instr_valid, 1);
      tick();
      check("bz0.next_instr", instr_out, 9'h042);
      check("bz0.next_valid", instr_valid, 1);
      zero_flag = 1'b1;
      do_start();
      tick(); tick();
      #0;
      check("bz1.jump", jump, 1);
      check("bz1.jump_value", jump_value, 8'd5);
      tick();
      check("bz1.bubble", instr_valid, 0);
      tick();
      check("bz1.target_instr", instr_out, 9'h043);
      check("bz1.target_valid", instr_valid, 1);
      check("bz1.pc", pc, 16'd6);
      zero_flag = 1'b0;

      // restart mid-run, then reset mid-run
      mem[0] = 9'h041; mem[1] = 9'h042; mem[2] = 9'h043; mem[3] = 9'h044; mem[4] = 9'h000;
      do_start();
      repeat (4) tick();
      check("rs.retired3", retired, 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rs.cleared", retired, 0);
      check("rs.discard", instr_valid, 0);
      tick();
      check("rs.first_instr", instr_out, 9'h041);
      check("rs.first_valid", instr_valid, 1);
      check("rs.pc", pc, 16'd1);
      tick();
      check("rs.retired1", retired, 1);
      reset = 1'b1;
      #1;
      check("rst.halt", halt, 1);
      check("rst.jump", jump, 0);
      check("rst.valid", instr_valid, 0);
      check("rst.retired", retired, 0);
      tick();
      reset = 1'b0;
      tick();
      check("rst.idle_halt", halt, 1);
      check("rst.idle_valid", instr_valid, 0);

      // back-to-back jumps: 0 -> 10 -> 12 -> 0
      mem[0] = 9'h1CA; mem[10] = 9'h1CC; mem[12] = 9'h1C0; mem[11] = 9'h041; mem[13] = 9'h041;
      do_start();
      tick();
      check("bb.j1", jump, 1);
      check("bb.j1_value", jump_value, 8'd10);
      check("bb.j1_retired", retired, 0);
      tick();
      check("bb.bubble1", instr_valid, 0);
      check("bb.bubble1_jump", jump, 0);
      tick();
      check("bb.j2_instr", instr_out, 9'h1CC);
      check("bb.j2", jump, 1);
      check("bb.j2_value", jump_value, 8'd12);
      check("bb.j2_retired", retired, 1);
      tick();
      check("bb.bubble2", instr_valid, 0);
      check("bb.bubble2_retired", retired, 2);
      tick();
      check("bb.j3_instr", instr_out, 9'h1C0);
      check("bb.j3", jump, 1);
      check("bb.j3_value", jump_value, 8'd0);
      check("bb.j3_retired", retired, 2);
      tick();
      check("bb.bubble3", instr_valid, 0);
      check("bb.retired3", retired, 3);

      // saturation: 21 retirements into a 4-bit counter
      for (int i = 0; i < 20; i++) mem[i] = 9'h041;
      mem[20] = 9'h000;
      do_start();
      begin
         int n;
         bit seen_done;
         n = 0;
         seen_done = 1'b0;
         for (int i = 0; i < 60 && !seen_done; i++) begin
            tick();
            if (instr_valid) n++;
            if (done) seen_done = 1'b1;
         end
         check("sat.done_seen", seen_done, 1);
         check("sat.valid_count", n, 21);
         check("sat.retired", retired, 15);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
